shared_port_sched: RTL
======================

SHARED_PORT_SCHED -- requirements
Module: shared_port_sched

Interface
REQ-001 Parameter NREQ, default 4, number of requesters; fixed at 4 in this revision.
REQ-002 Parameter LEN_W, default 4, width of each burst-length field.
REQ-003 Parameter TMO, default 16, stall cycles before a watchdog abort.
REQ-004 clk  input  1  single clock; all state updates on posedge clk.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 request  input  4  per-requester access request; level; held for the whole burst.
REQ-007 burst_len  input  16  per-requester beats-minus-one; field i = bits [4i+3:4i].
REQ-008 port_ready  input  1  shared port accepts a beat this cycle.
REQ-009 grant  output  4  one-hot owner of the shared port; all-zero when unowned.
REQ-010 grant_id  output  2  binary index of the current or most recent owner.
REQ-011 beat_valid  output  1  beat offered to the port this cycle.
REQ-012 busy  output  1  high in any state other than IDLE.
REQ-013 tmo_err  output  1  one-cycle pulse on a watchdog abort.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, OWN and REL.
REQ-015 IDLE, request != 0: select a winner round-robin, searching from last_id+1 mod 4 upward with wrap; load beat_cnt = burst_len[winner]; clear stall_cnt; go to OWN.
REQ-016 IDLE, request == 0: remain in IDLE; grant = 0.
REQ-017 Grant latency is 1 cycle: a request sampled in IDLE at edge t gives grant one-hot from edge t+1.
REQ-018 OWN: grant = one-hot(winner); beat_valid = 1; grant_id = winner.
REQ-019 OWN, port_ready = 1 and beat_cnt > 0: decrement beat_cnt; clear stall_cnt.
REQ-020 OWN, port_ready = 1 and beat_cnt == 0: last beat accepted; go to REL.
REQ-021 OWN, port_ready = 0: increment stall_cnt; on reaching TMO-1, pulse tmo_err for one cycle and go to REL.
REQ-022 OWN, request[winner] = 0: abort; go to REL; beat_valid deasserts the next cycle.
REQ-023 Priority of simultaneous OWN events: last-beat completion beats request drop, and request drop beats timeout. Only one transition is taken.
REQ-024 REL: grant = 0; beat_valid = 0; last_id <= winner; always go to IDLE after 1 cycle.
REQ-025 Back-to-back ownership SHALL show a 2-cycle grant gap (REL, then IDLE arbitration).
REQ-026 A burst of burst_len = L with port_ready held high SHALL keep grant asserted for exactly L+1 cycles.
REQ-027 burst_len and request of non-winners are ignored outside IDLE; burst_len is sampled only at the IDLE->OWN transition.
REQ-028 grant SHALL be one-hot or zero at all times, and grant != 0 only in OWN.

Reset
REQ-029 rst SHALL override every other input on the same edge, including mid-burst.
REQ-030 Reset values: state = IDLE, grant = 0, grant_id = 0, beat_valid = 0, busy = 0, tmo_err = 0, beat_cnt = 0, stall_cnt = 0, last_id = 3.
REQ-031 With last_id = 3, the first arbitration after reset SHALL give requester 0 highest priority.

Structure
REQ-032 A shared package SHALL hold the state enum (IDLE/OWN/REL) and the constants NREQ, LEN_W and TMO defaults.
REQ-033 Round-robin selection SHALL be a combinational sub-module rr_pick with inputs request[3:0] and last_id[1:0], and outputs winner[1:0] and any.
REQ-034 Outputs SHALL be registered; no combinational path from request or port_ready to grant.

Verification
REQ-035 Reset, then request = 4'b1111, all burst_len = 0, port_ready = 1 -> grants in order 0001, 0010, 0100, 1000, 0001, each 1 cycle wide with a 2-cycle gap between grants.
REQ-036 request = 4'b0100, burst_len[2] = 3, port_ready = 1 -> grant = 0100 for exactly 4 cycles, beat_valid high for those 4 cycles, then REL, then IDLE.
REQ-037 request = 4'b0001, burst_len[0] = 5, port_ready held 0 -> tmo_err pulses once after 16 OWN cycles; grant drops the next cycle; beat_cnt is unused.
REQ-038 Requester 1 owns with burst_len = 7, and request[1] drops at the 3rd beat -> REL on the next edge; the next arbitration starts its search at requester 2.
REQ-039 rst asserted during the 2nd beat of a burst of length 4 -> next cycle shows all outputs at reset values; a subsequent request = 4'b1010 is granted to requester 1.
REQ-040 On the last beat, port_ready = 1 and request[winner] drops simultaneously -> treated as a completion; tmo_err stays 0 and last_id updates to the winner.

Source files
------------

// File: rtl/shared_port_sched_pkg.sv
// ---------------------------------------------------------------------------
// shared_port_sched_pkg
// Shared definitions for the shared-port burst scheduler:
//   - state_t      : scheduler FSM states (IDLE / OWN / REL)
//   - NREQ_DEF     : default number of requesters (fixed at 4)
//   - LEN_W_DEF    : default width of one burst-length field
//   - TMO_DEF      : default stall cycles before a watchdog abort
//   - ID_W         : width of a requester index
//   - id_to_onehot : requester index to one-hot grant vector
// ---------------------------------------------------------------------------
package shared_port_sched_pkg;

  localparam int NREQ_DEF  = 4;
  localparam int LEN_W_DEF = 4;
  localparam int TMO_DEF   = 16;
  localparam int ID_W      = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    REL  = 2'd2
  } state_t;

  function automatic logic [NREQ_DEF-1:0] id_to_onehot(input logic [ID_W-1:0] id);
    logic [NREQ_DEF-1:0] oh;
    oh     = '0;
    oh[id] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/shared_port_sched_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin selector for four requesters. The search starts
// one past the most recent owner and wraps, so the last owner has the lowest
// priority.
// Ports:
//   request [3:0] in  : active requests
//   last_id [1:0] in  : index of the most recent owner
//   winner  [1:0] out : selected requester (0 when none)
//   any           out : at least one request is active
// ---------------------------------------------------------------------------
module rr_pick
  import shared_port_sched_pkg::*;
(
  input  logic [3:0]      request,
  input  logic [ID_W-1:0] last_id,
  output logic [ID_W-1:0] winner,
  output logic            any
);

  logic [ID_W-1:0] idx;

  // Walk the four candidates in rotated order; the first active one wins.
  // The 2-bit add wraps naturally, and i = 4 comes back to last_id itself.
  always_comb begin
    winner = '0;
    any    = 1'b0;
    idx    = '0;
    for (int i = 1; i <= 4; i++) begin
      idx = last_id + ID_W'(i);
      if (!any && request[idx]) begin
        winner = idx;
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/shared_port_sched.sv
// ---------------------------------------------------------------------------
// shared_port_sched
// Grants one of four requesters ownership of a shared port for a burst of
// beats. Arbitration is round-robin. A release cycle follows every ownership,
// and a watchdog aborts a burst that stalls too long. All outputs are
// registered.
// Ports:
//   clk, rst         in  : clock; synchronous active-high reset
//   request    [3:0] in  : per-requester level request, held for the burst
//   burst_len [15:0] in  : per-requester beats-minus-one, field i = [4i+3:4i]
//   port_ready       in  : the shared port accepts a beat this cycle
//   grant      [3:0] out : one-hot owner, zero when the port is unowned
//   grant_id   [1:0] out : index of the current or most recent owner
//   beat_valid       out : a beat is offered to the port
//   busy             out : the scheduler is not idle
//   tmo_err          out : one-cycle pulse when the watchdog aborts a burst
// ---------------------------------------------------------------------------
module shared_port_sched
  import shared_port_sched_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int LEN_W = LEN_W_DEF,
  parameter int TMO   = TMO_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       request,
  input  logic [NREQ*LEN_W-1:0] burst_len,
  input  logic                  port_ready,
  output logic [NREQ-1:0]       grant,
  output logic [ID_W-1:0]       grant_id,
  output logic                  beat_valid,
  output logic                  busy,
  output logic                  tmo_err
);

  // The stall counter only has to reach TMO-1.
  localparam int STALL_W = (TMO > 2) ? $clog2(TMO) : 1;

  state_t              state_q, state_d;
  logic [ID_W-1:0]     owner_q, owner_d;
  logic [ID_W-1:0]     last_id_q;
  logic [ID_W-1:0]     pick_winner;
  logic                pick_any;
  logic [LEN_W-1:0]    pick_len;
  logic [LEN_W-1:0]    beat_cnt_q;
  logic [STALL_W-1:0]  stall_cnt_q;
  logic                last_beat, req_drop, stall_tmo;
  logic [NREQ-1:0]     grant_d;
  logic                beat_valid_d, busy_d, tmo_err_d;

  rr_pick u_rr_pick (
    .request (request),
    .last_id (last_id_q),
    .winner  (pick_winner),
    .any     (pick_any)
  );

  assign pick_len = burst_len[int'(pick_winner)*LEN_W +: LEN_W];

  // Events that can end an ownership. Their priority (completion, then drop,
  // then timeout) is resolved where tmo_err is decoded; any of them leaves OWN.
  assign last_beat = port_ready && (beat_cnt_q == '0);
  assign req_drop  = !request[owner_q];
  assign stall_tmo = !port_ready && (stall_cnt_q == STALL_W'(TMO - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state. The owner index changes only when a new winner is taken.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d = OWN;
          owner_d = pick_winner;
        end
      end
      OWN: begin
        if (last_beat || req_drop || stall_tmo) begin
          state_d = REL;
        end
      end
      REL: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output decode from the next state, so the registered outputs line up
  // with the state register.
  always_comb begin
    grant_d      = '0;
    beat_valid_d = 1'b0;
    busy_d       = (state_d != IDLE);
    if (state_d == OWN) begin
      grant_d      = id_to_onehot(owner_d);
      beat_valid_d = 1'b1;
    end
    // A timeout is reported only when neither a completion nor a request
    // drop happens on the same cycle.
    tmo_err_d = (state_q == OWN) && !last_beat && !req_drop && stall_tmo;
  end

  // Beat and stall counters, round-robin pointer, and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q     <= '0;
      last_id_q   <= ID_W'(3);
      beat_cnt_q  <= '0;
      stall_cnt_q <= '0;
      grant       <= '0;
      grant_id    <= '0;
      beat_valid  <= 1'b0;
      busy        <= 1'b0;
      tmo_err     <= 1'b0;
    end else begin
      owner_q    <= owner_d;
      grant      <= grant_d;
      grant_id   <= owner_d;
      beat_valid <= beat_valid_d;
      busy       <= busy_d;
      tmo_err    <= tmo_err_d;
      case (state_q)
        IDLE: begin
          if (pick_any) begin
            beat_cnt_q  <= pick_len;
            stall_cnt_q <= '0;
          end
        end
        OWN: begin
          if (port_ready) begin
            if (beat_cnt_q != '0) begin
              beat_cnt_q <= beat_cnt_q - LEN_W'(1);
            end
            stall_cnt_q <= '0;
          end else if (!stall_tmo) begin
            stall_cnt_q <= stall_cnt_q + STALL_W'(1);
          end
        end
        REL: begin
          last_id_q <= owner_q;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
